// File: rtl/elevator_disp_pkg.sv
// Shared constants for the multiplexed seven-segment display.
// Glyphs are active-low and ordered {g,f,e,d,c,b,a}.
package elevator_disp_pkg;

  typedef logic [6:0] glyph_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam glyph_t GLYPH_0 = 7'h40;
  localparam glyph_t GLYPH_1 = 7'h79;
  localparam glyph_t GLYPH_2 = 7'h24;
  localparam glyph_t GLYPH_3 = 7'h30;
  localparam glyph_t GLYPH_4 = 7'h19;
  localparam glyph_t GLYPH_5 = 7'h12;
  localparam glyph_t GLYPH_6 = 7'h02;
  localparam glyph_t GLYPH_7 = 7'h78;
  localparam glyph_t GLYPH_8 = 7'h00;
  localparam glyph_t GLYPH_9 = 7'h10;
  localparam glyph_t GLYPH_A = 7'h08;
  localparam glyph_t GLYPH_B = 7'h03;
  localparam glyph_t GLYPH_C = 7'h46;
  localparam glyph_t GLYPH_D = 7'h21;
  localparam glyph_t GLYPH_E = 7'h06;
  localparam glyph_t GLYPH_F = 7'h0E;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module seg_hex_decode
  import elevator_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  // Map each hex value onto its segment pattern.
  always_comb begin
    glyph = GLYPH_0;
    unique case (nibble)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      4'hF: glyph = GLYPH_F;
      default: glyph = GLYPH_0;
    endcase
  end

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed seven-segment scanner. Inputs are snapshotted once per
// frame so a frame never shows a mix of old and new values, and the
// anode/cathode outputs are registered so they move together with scan_idx.
module seg_scan_display
  import elevator_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    ck,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   blink,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [2:0]              scan_idx,
  output logic                    frame_start
);

  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]        pre_q, pre_d;
  logic [2:0]              scan_idx_q, scan_idx_d;
  logic [FRM_W-1:0]        frame_q, frame_d;
  logic                    phase_q, phase_d;
  logic                    frame_start_q, frame_start_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              seg_q, seg_d;
  logic [4*NUM_DIGITS-1:0] sh_digits_q, sh_digits_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
  logic [NUM_DIGITS-1:0]   sh_blink_q, sh_blink_d;

  logic                    tick;
  logic                    wrap;
  logic [3:0]              cur_nibble;
  logic                    cur_dp;
  logic                    cur_blank;
  logic                    cur_blink;
  logic                    cur_dark;
  logic [NUM_DIGITS-1:0]   cur_sel;
  logic [6:0]              glyph;

  // Prescaler, slot index, frame snapshot and blink phase bookkeeping.
  always_comb begin
    tick          = (pre_q == PRE_LAST);
    wrap          = tick && (scan_idx_q == IDX_LAST);
    pre_d         = tick ? '0 : pre_q + PRE_W'(1);
    scan_idx_d    = scan_idx_q;
    frame_d       = frame_q;
    phase_d       = phase_q;
    frame_start_d = wrap;
    sh_digits_d   = sh_digits_q;
    sh_dp_d       = sh_dp_q;
    sh_blank_d    = sh_blank_q;
    sh_blink_d    = sh_blink_q;
    if (tick) begin
      scan_idx_d = wrap ? 3'd0 : scan_idx_q + 3'd1;
    end
    if (wrap) begin
      sh_digits_d = digits;
      sh_dp_d     = dp;
      sh_blank_d  = blank;
      sh_blink_d  = blink;
      if (frame_q == FRM_LAST) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + FRM_W'(1);
      end
    end
  end

  // Pick the attributes of the slot being entered, using the post-capture shadows.
  always_comb begin
    cur_nibble = 4'h0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    cur_blink  = 1'b0;
    cur_sel    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx_d == 3'(i)) begin
        cur_nibble = sh_digits_d[4*i +: 4];
        cur_dp     = sh_dp_d[i];
        cur_blank  = sh_blank_d[i];
        cur_blink  = sh_blink_d[i];
        cur_sel[i] = 1'b1;
      end
    end
    cur_dark = cur_blank | (cur_blink & phase_d);
  end

  seg_hex_decode u_hex_decode (
    .nibble (cur_nibble),
    .glyph  (glyph)
  );

  // Next anode/cathode drive, refreshed only when the slot changes.
  always_comb begin
    an_d  = an_q;
    seg_d = seg_q;
    if (tick) begin
      if (cur_dark) begin
        an_d  = '1;
        seg_d = SEG_OFF;
      end else begin
        an_d  = ~cur_sel;
        seg_d = {~cur_dp, glyph};
      end
    end
  end

  // State registers; reset leaves the display dark until the first snapshot.
  always_ff @(posedge ck) begin
    if (!rst_n) begin
      pre_q         <= '0;
      scan_idx_q    <= 3'd0;
      frame_q       <= '0;
      phase_q       <= 1'b0;
      frame_start_q <= 1'b0;
      an_q          <= '1;
      seg_q         <= SEG_OFF;
      sh_digits_q   <= '0;
      sh_dp_q       <= '0;
      sh_blank_q    <= '1;
      sh_blink_q    <= '0;
    end else begin
      pre_q         <= pre_d;
      scan_idx_q    <= scan_idx_d;
      frame_q       <= frame_d;
      phase_q       <= phase_d;
      frame_start_q <= frame_start_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      sh_digits_q   <= sh_digits_d;
      sh_dp_q       <= sh_dp_d;
      sh_blank_q    <= sh_blank_d;
      sh_blink_q    <= sh_blink_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign scan_idx    = scan_idx_q;
  assign frame_start = frame_start_q;

endmodule
